// File: rtl/posit_stream_accumulator.sv
`default_nettype none
// ============================================================================
// posit_stream_accumulator
// Folds a posit stream through an external LAT-cycle pipelined posit adder,
// recycling partial sums until one value remains; emits it with valid/ready.
// Revision: 1.0
// ============================================================================
module posit_stream_accumulator #(
    parameter int N   = 8,
    parameter int LAT = 6,
    parameter int CW  = 16
) (
    input  logic          aclk,
    input  logic          aresetn,
    input  logic [N-1:0]  in_data,
    input  logic          in_valid,
    input  logic          in_last,
    output logic          in_ready,
    output logic [N-1:0]  add_in1,
    output logic [N-1:0]  add_in2,
    output logic          add_start,
    input  logic [N-1:0]  add_result,
    input  logic          add_inf,
    input  logic          add_done,
    output logic [N-1:0]  sum_data,
    output logic          sum_inf,
    output logic [CW-1:0] sum_count,
    output logic          sum_valid,
    input  logic          sum_ready
);

    localparam int            IW  = $clog2(LAT + 3);
    localparam logic [N-1:0]  NAR = {1'b1, {(N-1){1'b0}}};

    typedef enum logic [1:0] {
        ACCUM = 2'd0,
        DRAIN = 2'd1,
        OUT   = 2'd2
    } state_t;

    state_t         state;
    logic [N-1:0]   hold;
    logic           hold_valid;
    logic [IW-1:0]  inflight;
    logic           inf_acc;
    logic [CW-1:0]  count;

    logic           fire;
    logic           done_ok;
    logic           src_r;
    logic           src_i;
    logic           src_h;
    logic           drain_exit;
    logic           out_take;
    logic           issue;
    logic [N-1:0]   op_a;
    logic [N-1:0]   op_b;
    logic [N-1:0]   hold_next;
    logic           hold_valid_next;
    logic [IW-1:0]  inflight_next;

    // Results with nothing outstanding (e.g. launched before a reset) are dropped.
    always_comb begin
        fire       = in_valid & in_ready;
        done_ok    = add_done & (inflight != '0);
        src_r      = done_ok & (state != OUT);
        src_i      = fire;
        src_h      = hold_valid & (state != OUT);
        drain_exit = (state == DRAIN) & hold_valid & (inflight == '0) & ~add_done;
        out_take   = (state == OUT) & sum_ready;
    end

    // Pair up to two of {returned sum, new element, held value} in that order.
    always_comb begin
        issue           = 1'b0;
        op_a            = hold;
        op_b            = hold;
        hold_next       = hold;
        hold_valid_next = hold_valid;
        if (src_r && src_i) begin
            issue           = 1'b1;
            op_a            = add_result;
            op_b            = in_data;
            hold_valid_next = src_h;
        end else if (src_r && src_h) begin
            issue           = 1'b1;
            op_a            = add_result;
            op_b            = hold;
            hold_valid_next = 1'b0;
        end else if (src_i && src_h) begin
            issue           = 1'b1;
            op_a            = in_data;
            op_b            = hold;
            hold_valid_next = 1'b0;
        end else if (src_r) begin
            hold_next       = add_result;
            hold_valid_next = 1'b1;
        end else if (src_i) begin
            hold_next       = in_data;
            hold_valid_next = 1'b1;
        end
        if (drain_exit) begin
            hold_valid_next = 1'b0;
        end
    end

    always_comb begin
        inflight_next = inflight;
        if (issue && !done_ok) begin
            inflight_next = inflight + IW'(1);
        end else if (!issue && done_ok) begin
            inflight_next = inflight - IW'(1);
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state      <= ACCUM;
            in_ready   <= 1'b1;
            hold       <= '0;
            hold_valid <= 1'b0;
            inflight   <= '0;
            inf_acc    <= 1'b0;
            count      <= '0;
            add_start  <= 1'b0;
            add_in1    <= '0;
            add_in2    <= '0;
            sum_data   <= '0;
            sum_inf    <= 1'b0;
            sum_count  <= '0;
            sum_valid  <= 1'b0;
        end else begin
            hold       <= hold_next;
            hold_valid <= hold_valid_next;
            inflight   <= inflight_next;
            add_start  <= issue;
            if (issue) begin
                add_in1 <= op_a;
                add_in2 <= op_b;
            end

            if (out_take) begin
                inf_acc <= 1'b0;
            end else if ((done_ok && add_inf) || (fire && in_data == NAR)) begin
                inf_acc <= 1'b1;
            end

            if (out_take) begin
                count <= '0;
            end else if (fire && count != '1) begin
                count <= count + CW'(1);
            end

            case (state)
                ACCUM: begin
                    if (fire && in_last) begin
                        state    <= DRAIN;
                        in_ready <= 1'b0;
                    end
                end
                DRAIN: begin
                    if (drain_exit) begin
                        state     <= OUT;
                        sum_valid <= 1'b1;
                        sum_data  <= hold;
                        sum_inf   <= inf_acc;
                        sum_count <= count;
                    end
                end
                OUT: begin
                    if (sum_ready) begin
                        state     <= ACCUM;
                        sum_valid <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: begin
                    state <= ACCUM;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
